// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit ALU between NREQ requesters, with a
// two-stage operand/result pipeline. Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arb_en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [16*NREQ-1:0] req_a,
    input  logic [16*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0]  req_func,
    output logic [NREQ-1:0]    req_ready,
    output logic [15:0]        alu_a,
    output logic [15:0]        alu_b,
    output logic [2:0]         alu_func,
    input  logic [15:0]        alu_r,
    input  logic               alu_zf,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [15:0]        rsp_result,
    output logic               rsp_zf,
    output logic               busy
);

    // Handshake: requester i transfers an op on a rising edge where req_valid[i] & req_ready[i];
    // req_ready is one-hot, only offered to a valid requester, and never waits on the response side.
    logic            grant_any;
    logic [IDW-1:0]  grant_id;
    logic            hs;

    logic [15:0]     op_a_d, op_b_d;
    logic [2:0]      op_func_d;
    logic [15:0]     op_a_q, op_b_q;
    logic [2:0]      op_func_q;
    logic [IDW-1:0]  op_id_q;
    logic            op_v_q;

    logic [15:0]     res_q;
    logic            zf_q;
    logic [IDW-1:0]  rsp_id_q;
    logic            rsp_v_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
    // Descending scan so the lowest valid index is the last (winning) assignment.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        if (arb_en && rst_n) begin
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (req_valid[k]) begin
                    grant_any = 1'b1;
                    grant_id  = IDW'(k);
                end
            end
        end
    end
`else
    logic [IDW-1:0]  rr_ptr_q;

    // Scan offsets NREQ..1 from the pointer; the nearest valid requester after rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        if (arb_en && rst_n) begin
            for (int k = NREQ; k >= 1; k--) begin
                if (req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                    grant_any = 1'b1;
                    grant_id  = IDW'((int'(rr_ptr_q) + k) % NREQ);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= IDW'(NREQ - 1);
        end else if (hs) begin
            rr_ptr_q <= grant_id;
        end
    end
`endif

    always_comb begin
        req_ready = '0;
        op_a_d    = '0;
        op_b_d    = '0;
        op_func_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_any && (grant_id == IDW'(i))) begin
                req_ready[i] = 1'b1;
                op_a_d       = req_a[16*i +: 16];
                op_b_d       = req_b[16*i +: 16];
                op_func_d    = req_func[3*i +: 3];
            end
        end
    end

    assign hs = |(req_valid & req_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            op_func_q <= '0;
            op_id_q   <= '0;
            op_v_q    <= 1'b0;
            res_q     <= '0;
            zf_q      <= 1'b0;
            rsp_id_q  <= '0;
            rsp_v_q   <= 1'b0;
        end else begin
            op_v_q  <= hs;
            rsp_v_q <= op_v_q;
            // Operand register only loads on a handshake so the ALU inputs stay quiet when idle.
            if (hs) begin
                op_a_q    <= op_a_d;
                op_b_q    <= op_b_d;
                op_func_q <= op_func_d;
                op_id_q   <= grant_id;
            end
            if (op_v_q) begin
                res_q    <= alu_r;
                zf_q     <= alu_zf;
                rsp_id_q <= op_id_q;
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid[i] = rsp_v_q && (rsp_id_q == IDW'(i));
        end
    end

    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_func   = op_func_q;
    assign rsp_result = res_q;
    assign rsp_zf     = zf_q;
    assign busy       = op_v_q | rsp_v_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter (NREQ=2) with a behavioural ALU closing the loop.
// Compile with ALU_ARB_FIXED_PRIO_EN defined to exercise the fixed-priority build.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        arb_en;
    logic [1:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [5:0]  req_func;
    logic [1:0]  req_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [2:0]  alu_func;
    logic [15:0] alu_r;
    logic        alu_zf;
    logic [1:0]  rsp_valid;
    logic [15:0] rsp_result;
    logic        rsp_zf;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    alu_arbiter #(.NREQ(2), .IDW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .arb_en     (arb_en),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_func   (req_func),
        .req_ready  (req_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_func   (alu_func),
        .alu_r      (alu_r),
        .alu_zf     (alu_zf),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_zf     (rsp_zf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        case (alu_func)
            3'b000:  alu_r = alu_a + alu_b;
            3'b001:  alu_r = alu_a - alu_b;
            3'b010:  alu_r = alu_a & alu_b;
            3'b011:  alu_r = alu_a | alu_b;
            3'b100:  alu_r = ~(alu_a | alu_b);
            3'b101:  alu_r = alu_a ^ alu_b;
            3'b110:  alu_r = alu_a << alu_b[3:0];
            default: alu_r = alu_a >> alu_b[3:0];
        endcase
    end
    assign alu_zf = (alu_r == 16'h0000);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [2:0] f, input logic [15:0] a, input logic [15:0] b);
        req_valid[i]       = 1'b1;
        req_func[3*i +: 3] = f;
        req_a[16*i +: 16]  = a;
        req_b[16*i +: 16]  = b;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        arb_en    = 1'b1;
        req_valid = 2'b00;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        arb_en    = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_func  = '0;
        cyc();
        cyc();
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
        checks++; if (rsp_result !== 16'h0000) begin failures++; $display("FAIL reset_rsp_result got=%h exp=0000", rsp_result); end
        checks++; if (rsp_zf !== 1'b0) begin failures++; $display("FAIL reset_rsp_zf got=%b exp=0", rsp_zf); end
        checks++; if ({alu_a, alu_b, alu_func} !== 35'h0) begin failures++; $display("FAIL reset_alu_ops got=%h/%h/%b exp=0", alu_a, alu_b, alu_func); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst_n     = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_single_add();
        cyc();
        set_req(0, 3'b000, 16'd1, 16'd1);
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL add_ready got=%b exp=01", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL add_early_rsp got=%b exp=00", rsp_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", busy); end
        checks++; if ({alu_a, alu_b, alu_func} !== {16'd1, 16'd1, 3'b000}) begin failures++; $display("FAIL add_alu_ops got=%h/%h/%b exp=0001/0001/000", alu_a, alu_b, alu_func); end
        cyc();
        checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL add_rsp_valid got=%b exp=01", rsp_valid); end
        checks++; if (rsp_result !== 16'h0002) begin failures++; $display("FAIL add_result got=%h exp=0002", rsp_result); end
        checks++; if (rsp_zf !== 1'b0) begin failures++; $display("FAIL add_zf got=%b exp=0", rsp_zf); end
        cyc();
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL add_pulse_end got=%b exp=00", rsp_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_idle_busy got=%b exp=0", busy); end
        checks++; if (alu_a !== 16'd1) begin failures++; $display("FAIL add_alu_hold got=%h exp=0001", alu_a); end
    endtask

`ifdef ALU_ARB_FIXED_PRIO_EN
    task automatic test_fixed_prio();
        logic [1:0] exp_rdy;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cyc();
            set_req(0, 3'b000, 16'd3, 16'd4);
            set_req(1, 3'b000, 16'd5, 16'd6);
            if (c == 3) req_valid[0] = 1'b0;
            exp_rdy = (c == 3) ? 2'b10 : 2'b01;
            #1;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL fixed_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
        end
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
    endtask
`else
    task automatic test_round_robin();
        logic [1:0]  exp_rdy;
        logic [1:0]  exp_v;
        logic [15:0] exp_r;
        logic        exp_z;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            cyc();
            if (c < 4) begin
                set_req(0, 3'b001, 16'h000F, 16'h000F);
                set_req(1, 3'b010, 16'hAAAA, 16'hCCCC);
            end else begin
                req_valid = 2'b00;
            end
            #1;
            if (c < 4) begin
                exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
                checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            end
            if (c >= 2) begin
                exp_v = (c % 2 == 0) ? 2'b01 : 2'b10;
                exp_r = (c % 2 == 0) ? 16'h0000 : 16'h8888;
                exp_z = (c % 2 == 0);
                checks++; if ({rsp_valid, rsp_result, rsp_zf} !== {exp_v, exp_r, exp_z}) begin
                    failures++; $display("FAIL rr_rsp c=%0d got=%b/%h/%b exp=%b/%h/%b", c, rsp_valid, rsp_result, rsp_zf, exp_v, exp_r, exp_z);
                end
            end
        end
        cyc();
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rr_drain got=%b exp=00", rsp_valid); end
    endtask
`endif

    task automatic test_back_to_back();
        cyc();
        req_valid = 2'b00;
        set_req(1, 3'b011, 16'hABCD, 16'hDDDD);
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL b2b_ready0 got=%b exp=10", req_ready); end
        cyc();
        set_req(1, 3'b100, 16'hABCD, 16'hDDDD);
        #1;
        checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL b2b_ready1 got=%b exp=10", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++; if ({rsp_valid, rsp_result, rsp_zf} !== {2'b10, 16'hFFDD, 1'b0}) begin failures++; $display("FAIL b2b_or got=%b/%h/%b exp=10/ffdd/0", rsp_valid, rsp_result, rsp_zf); end
        cyc();
        checks++; if ({rsp_valid, rsp_result, rsp_zf} !== {2'b10, 16'h0022, 1'b0}) begin failures++; $display("FAIL b2b_nor got=%b/%h/%b exp=10/0022/0", rsp_valid, rsp_result, rsp_zf); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        cyc();
        checks++; if ({rsp_valid, busy} !== 3'b000) begin failures++; $display("FAIL b2b_idle got=%b/%b exp=00/0", rsp_valid, busy); end
        checks++; if (alu_func !== 3'b100) begin failures++; $display("FAIL b2b_func_hold got=%b exp=100", alu_func); end
    endtask

    task automatic test_arb_disable();
        cyc();
        req_valid = 2'b00;
        set_req(0, 3'b101, 16'd20, 16'd30);
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL dis_ready0 got=%b exp=01", req_ready); end
        cyc();
        arb_en = 1'b0;
        set_req(1, 3'b000, 16'd7, 16'd8);
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL dis_ready1 got=%b exp=00", req_ready); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL dis_busy1 got=%b exp=1", busy); end
        cyc();
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL dis_ready2 got=%b exp=00", req_ready); end
        checks++; if ({rsp_valid, rsp_result, busy} !== {2'b01, 16'h000A, 1'b1}) begin failures++; $display("FAIL dis_rsp got=%b/%h/%b exp=01/000a/1", rsp_valid, rsp_result, busy); end
        cyc();
        checks++; if ({rsp_valid, busy} !== 3'b000) begin failures++; $display("FAIL dis_drain got=%b/%b exp=00/0", rsp_valid, busy); end
        arb_en    = 1'b1;
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_op();
        cyc();
        set_req(0, 3'b000, 16'd5, 16'd6);
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmo_ready0 got=%b exp=01", req_ready); end
        cyc();
        rst_n = 1'b0;
        set_req(1, 3'b000, 16'd9, 16'd9);
        #1;
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rmo_ready_in_reset got=%b exp=00", req_ready); end
        cyc();
        checks++; if ({rsp_valid, busy, rsp_result} !== {2'b00, 1'b0, 16'h0000}) begin failures++; $display("FAIL rmo_cleared got=%b/%b/%h exp=00/0/0000", rsp_valid, busy, rsp_result); end
        checks++; if ({alu_a, alu_b, alu_func} !== 35'h0) begin failures++; $display("FAIL rmo_alu_ops got=%h/%h/%b exp=0", alu_a, alu_b, alu_func); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rmo_ptr_reset got=%b exp=01", req_ready); end
        cyc();
        req_valid = 2'b00;
        #1;
        checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rmo_discard got=%b exp=00", rsp_valid); end
        cyc();
        checks++; if ({rsp_valid, rsp_result} !== {2'b01, 16'h000B}) begin failures++; $display("FAIL rmo_after got=%b/%h exp=01/000b", rsp_valid, rsp_result); end
        cyc();
        checks++; if ({rsp_valid, busy} !== 3'b000) begin failures++; $display("FAIL rmo_idle got=%b/%b exp=00/0", rsp_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_single_add();
`ifdef ALU_ARB_FIXED_PRIO_EN
        test_fixed_prio();
`else
        test_round_robin();
`endif
        test_back_to_back();
        test_arb_disable();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
